instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of Gambling_CPU, directly upstream of the asynchronous instruction ROM (AW=10, DW=32).
- Holds the PC and drives the ROM word address. Captures the returned word into a registered fetch/decode output with a valid/ready handshake toward decode.
- Also handles branch redirects from execute and detects fetches past the end of the loaded program.

Parameters:
AW, 10, ROM word-address width (1024 words)
DW, 32, instruction width
PROG_WORDS, 173, number of valid program words; fetch of word index >= PROG_WORDS is a fault
RESET_PC, 32'h0000_0000, byte PC loaded on reset
NOP_WORD, 32'hE1A0_0000, value of instr_o whenever instr_valid_o=0

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
rom_addr_o  out  AW  ROM word address = pc[AW+1:2], combinational from PC register
rom_data_i  in  DW  asynchronous ROM read data for rom_addr_o
instr_o  out  DW  registered instruction to decode
pc_o  out  32  byte address of instr_o
pc_plus4_o  out  32  pc_o + 4 (registered with instr_o)
instr_valid_o  out  1  instr_o/pc_o valid
instr_ready_i  in  1  decode accepts when valid & ready
redirect_i  in  1  branch taken; flush and jump
redirect_pc_i  in  32  byte target of redirect
fault_o  out  1  sticky fetch fault (out of range or misaligned)
fetch_count_o  out  32  number of accepted instructions (valid & ready), wraps mod 2^32

Behaviour:
- Reset values (rst sampled high at edge):
  - pc=RESET_PC; instr_o=NOP_WORD; pc_o=0; pc_plus4_o=0.
  - instr_valid_o=0; fault_o=0; fetch_count_o=0; state=IDLE.
- Reset applied mid-operation has priority over every other input and gives the same result.
- FSM:
  - IDLE: one bubble cycle after reset, valid stays 0. Next state RUN unconditionally, unless redirect_i, which is applied as in RUN.
  - RUN, with load = !instr_valid_o | instr_ready_i, evaluated in priority order:
    1. redirect_i=1:
       - instr_valid_o<=0 and instr_o<=NOP_WORD (flush; any word being accepted this cycle still counts).
       - If redirect_pc_i[1:0]!=0 or redirect_pc_i[31:2]>=PROG_WORDS: state<=FAULT, fault_o<=1, pc unchanged.
       - Otherwise pc<=redirect_pc_i.
       - The first redirected word is visible at instr_o after 2 edges.
    2. load=1 and pc[31:2]>=PROG_WORDS: state<=FAULT, fault_o<=1, instr_valid_o<=0, instr_o<=NOP_WORD.
    3. load=1: instr_o<=rom_data_i; pc_o<=pc; pc_plus4_o<=pc+4; instr_valid_o<=1; pc<=pc+4.
    4. Else (stall, valid & !ready): hold all registers; rom_addr_o is held stable.
  - FAULT: terminal until rst. valid=0, instr_o=NOP_WORD, fault_o=1. redirect_i and instr_ready_i are ignored.
- fetch_count_o increments on every edge with instr_valid_o & instr_ready_i, in any state, not in reset. 32-bit wrap: FFFF_FFFF -> 0.
- Throughput: 1 instruction/cycle with ready held high. Latency from pc change to instr_o is 1 edge.
- PC arithmetic is 32-bit unsigned. Bits above AW+1 never alias into rom_addr_o because of the range check.
- Output instr_o/pc_o never change while instr_valid_o=1 and instr_ready_i=0.

Decomposition:
- Package gambling_pkg holds: NOP_WORD constant; typedef enum logic [1:0] fetch_state_t {IDLE, RUN, FAULT}; typedef logic [31:0] pc_t.
- One sub-module, if_next_pc: combinational next-PC/fault-check mux (inputs pc, redirect, load, PROG_WORDS; outputs next_pc, fault_next).
- The ROM remains a separate instance wired at CPU top.

Test Plan:
- Reset then ready=1 with the ROM loaded from Gambling_Tec.hex -> cycle 1 valid=0. Then pc_o=0,4,8… on consecutive cycles and instr_o matches ROM[0],ROM[1]….
- Backpressure: ready=0 for 3 cycles after word 2 -> instr_o/pc_o=8 stable, rom_addr_o=3 stable, fetch_count_o unchanged. Ready=1 -> pc_o=0xC next.
- Redirect_i=1, redirect_pc_i=0x40 while a word at pc_o=0x10 is valid & ready -> count +1, valid=0 next cycle, then pc_o=0x40 with instr_o=ROM[16].
- Sequential run to end (PROG_WORDS=173) -> last valid pc_o=0x2B0. Next load -> fault_o=1, valid=0, fetch_count_o=173, outputs frozen despite later redirects.
- Misaligned redirect 0x42 and out-of-range redirect 0x2B4 (separate runs) -> fault_o=1 the next cycle, pc unchanged.
- rst asserted during a stall and in FAULT -> all outputs return to reset values on the next edge, fetch restarts at 0.

Source files
------------

// File: rtl/gambling_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gambling_pkg
// Brief    : Shared fetch-stage types and constants for Gambling_CPU.
// Revision : 1.0 - initial release
// ============================================================================
package gambling_pkg;

    localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef logic [31:0] pc_t;

endpackage
`default_nettype wire

// File: rtl/if_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : if_next_pc
// Brief    : Combinational next-PC select with redirect/range fault checks.
// Revision : 1.0 - initial release
// ============================================================================
module if_next_pc
    import gambling_pkg::*;
#(
    parameter int unsigned PROG_WORDS = 173
) (
    input  pc_t  i_pc,
    input  logic i_redirect,
    input  pc_t  i_redirect_pc,
    input  logic i_load,
    output pc_t  o_next_pc,
    output logic o_fault_next
);

    localparam logic [29:0] c_prog_words = 30'(PROG_WORDS);

    logic w_redirect_bad;
    logic w_pc_out_of_range;

    assign w_redirect_bad    = (i_redirect_pc[1:0] != 2'b00) ||
                               (i_redirect_pc[31:2] >= c_prog_words);
    assign w_pc_out_of_range = (i_pc[31:2] >= c_prog_words);

    // A faulting request leaves the PC where it is.
    always_comb begin
        o_next_pc    = i_pc;
        o_fault_next = 1'b0;
        if (i_redirect) begin
            if (w_redirect_bad) begin
                o_fault_next = 1'b1;
            end else begin
                o_next_pc = i_redirect_pc;
            end
        end else if (i_load) begin
            if (w_pc_out_of_range) begin
                o_fault_next = 1'b1;
            end else begin
                o_next_pc = i_pc + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: PC, ROM addressing, registered F/D output, redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned      AW         = 10,
    parameter int unsigned      DW         = 32,
    parameter int unsigned      PROG_WORDS = 173,
    parameter logic [31:0]      RESET_PC   = 32'h0000_0000,
    parameter logic [DW-1:0]    NOP_WORD   = DW'(gambling_pkg::NOP_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i,
    output logic [DW-1:0] instr_o,
    output logic [31:0]   pc_o,
    output logic [31:0]   pc_plus4_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          fault_o,
    output logic [31:0]   fetch_count_o
);

    import gambling_pkg::*;

    fetch_state_t  r_state, w_state_nxt;
    pc_t           r_pc, w_pc_nxt;
    logic [DW-1:0] r_instr, w_instr_nxt;
    pc_t           r_pc_out, w_pc_out_nxt;
    pc_t           r_pc_plus4, w_pc_plus4_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_fault, w_fault_nxt;
    logic [31:0]   r_fetch_count;

    logic w_load;
    pc_t  w_next_pc;
    logic w_fault_chk;

    assign w_load = !r_valid || instr_ready_i;

    if_next_pc #(
        .PROG_WORDS (PROG_WORDS)
    ) u_next_pc (
        .i_pc          (r_pc),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_load        ((r_state == RUN) && w_load),
        .o_next_pc     (w_next_pc),
        .o_fault_next  (w_fault_chk)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_out_nxt   = r_pc_out;
        w_pc_plus4_nxt = r_pc_plus4;
        w_valid_nxt    = r_valid;
        w_fault_nxt    = r_fault;
        case (r_state)
            IDLE, RUN: begin
                if (r_state == IDLE) begin
                    w_state_nxt = RUN;
                end
                // Redirect flushes the output slot even if it was accepted now.
                if (redirect_i) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_WORD;
                    if (w_fault_chk) begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_next_pc;
                    end
                end else if ((r_state == RUN) && w_load) begin
                    if (w_fault_chk) begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_instr_nxt = NOP_WORD;
                    end else begin
                        w_instr_nxt    = rom_data_i;
                        w_pc_out_nxt   = r_pc;
                        w_pc_plus4_nxt = r_pc + 32'd4;
                        w_valid_nxt    = 1'b1;
                        w_pc_nxt       = w_next_pc;
                    end
                end
            end
            FAULT: begin
                w_valid_nxt = 1'b0;
                w_instr_nxt = NOP_WORD;
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_WORD;
            r_pc_out      <= 32'd0;
            r_pc_plus4    <= 32'd0;
            r_valid       <= 1'b0;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_pc_plus4    <= w_pc_plus4_nxt;
            r_valid       <= w_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_count <= r_fetch_count + 32'(r_valid & instr_ready_i);
        end
    end

    assign rom_addr_o    = r_pc[AW+1:2];
    assign instr_o       = r_instr;
    assign pc_o          = r_pc_out;
    assign pc_plus4_o    = r_pc_plus4;
    assign instr_valid_o = r_valid;
    assign fault_o       = r_fault;
    assign fetch_count_o = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Scoreboard bench for instr_fetch_unit with a synthetic ROM image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          AW  = 10;
    localparam int          DW  = 32;
    localparam int          PW  = 173;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic [31:0]   pc_out;
    logic [31:0]   pc_plus4;
    logic          valid;
    logic          ready;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          fault;
    logic [31:0]   fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    instr_fetch_unit #(
        .AW         (AW),
        .DW         (DW),
        .PROG_WORDS (PW),
        .RESET_PC   (32'h0),
        .NOP_WORD   (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .instr_o       (instr),
        .pc_o          (pc_out),
        .pc_plus4_o    (pc_plus4),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fault_o       (fault),
        .fetch_count_o (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_words(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sb.push_back({32'(i * 4), rom_fn(10'(i))});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},    32'(valid), 32'd0);
        check({tag, "_instr"},    instr,      NOP);
        check({tag, "_pc"},       pc_out,     32'd0);
        check({tag, "_pc4"},      pc_plus4,   32'd0);
        check({tag, "_fault"},    32'(fault), 32'd0);
        check({tag, "_count"},    fetch_count, 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got pc %h instr %h expected no transfer", pc_out, instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("accept_pc",    pc_out,   e.pc);
                check("accept_instr", instr,    e.instr);
                check("accept_pc4",   pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_pc;
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        check_reset("reset");

        // Run 1: bubble, backpressure, redirect, reset during stall
        rst = 1'b0; ready = 1'b1;
        push_words(0, 2);
        step();
        check("bubble_valid", 32'(valid), 32'd0);
        step(); step(); step();
        check("w2_pc", pc_out, 32'h8);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc",       pc_out,        32'h8);
            check("stall_instr",    instr,         rom_fn(10'd2));
            check("stall_rom_addr", 32'(rom_addr), 32'd3);
            check("stall_count",    fetch_count,   32'd2);
        end
        ready = 1'b1;
        push_words(3, 4);
        step();
        check("resume_pc",    pc_out,      32'hC);
        check("resume_count", fetch_count, 32'd3);
        step();
        check("w4_pc", pc_out, 32'h10);
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        check("redir_valid", 32'(valid),  32'd0);
        check("redir_instr", instr,       NOP);
        check("redir_count", fetch_count, 32'd5);
        redirect = 1'b0;
        push_words(16, 17);
        step();
        check("redir_pc",    pc_out, 32'h40);
        check("redir_word",  instr,  rom_fn(10'd16));
        step(); step();
        check("w18_pc", pc_out, 32'h48);
        ready = 1'b0;
        step();
        check("stall2_count", fetch_count, 32'd7);
        rst = 1'b1;
        step();
        check_reset("rst_stall");

        // Run 2: sequential run to end of program
        rst = 1'b0; ready = 1'b1;
        push_words(0, PW - 1);
        last_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 400 && !fault; k++) begin
            step();
            if (valid) last_pc = pc_out;
        end
        check("end_fault",   32'(fault), 32'd1);
        check("end_last_pc", last_pc,    32'h2B0);
        check("end_valid",   32'(valid), 32'd0);
        check("end_instr",   instr,      NOP);
        check("end_count",   fetch_count, 32'd173);
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h40;
        for (int k = 0; k < 3; k++) begin
            ready = (k != 1);
            step();
            check("frozen_pc",       pc_out,        32'h2B0);
            check("frozen_valid",    32'(valid),    32'd0);
            check("frozen_fault",    32'(fault),    32'd1);
            check("frozen_count",    fetch_count,   32'd173);
            check("frozen_rom_addr", 32'(rom_addr), 32'd173);
        end
        redirect = 1'b0;
        rst = 1'b1; ready = 1'b0;
        step();
        check_reset("rst_fault");

        // Run 3: misaligned redirect
        rst = 1'b0; ready = 1'b1;
        push_words(0, 1);
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        check("misal_fault",    32'(fault),    32'd1);
        check("misal_valid",    32'(valid),    32'd0);
        check("misal_rom_addr", 32'(rom_addr), 32'd2);
        check("misal_count",    fetch_count,   32'd2);
        redirect = 1'b0;
        step();
        check("misal_sticky", 32'(fault), 32'd1);
        rst = 1'b1; ready = 1'b0;
        step();

        // Run 4: out-of-range redirect
        rst = 1'b0; ready = 1'b1;
        push_words(0, 0);
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h2B4;
        step();
        check("oor_fault",    32'(fault),    32'd1);
        check("oor_valid",    32'(valid),    32'd0);
        check("oor_rom_addr", 32'(rom_addr), 32'd1);
        check("oor_count",    fetch_count,   32'd1);
        redirect = 1'b0;
        step();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
